wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback stage in front of the 16×16-bit register file. It merges single-cycle ALU results and variable-latency load returns onto the file's single write port, through a registered write interface of DstReg, WriteReg and DstData. A per-register load scoreboard plus a small ALU result FIFO tell decode which source registers are not yet safe to read from the file.

## Interface
- DEPTH, 2, ALU result FIFO entries (legal 2..4)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- AluValid  in  1  ALU result presented this cycle
- AluReg  in  4  ALU destination register
- AluData  in  16  ALU result
- AluReady  out  1  ALU result accepted this cycle when AluValid=1
- LdValid  in  1  load return presented
- LdReg  in  4  load destination register
- LdData  in  16  load data
- LdReady  out  1  load return accepted this cycle when LdValid=1
- IssueLd  in  1  decode issues a load this cycle
- IssueReg  in  4  destination of the issued load
- QueryReg1, QueryReg2  in  4 each  decode source registers
- Busy1, Busy2  out  1 each  queried register has a pending write
- DstReg  out  4  register-file write address (registered)
- WriteReg  out  1  register-file write enable (registered)
- DstData  out  16  register-file write data (registered)

## Operation
- ALU path: AluValid & AluReady pushes {AluReg, AluData} into the FIFO.
- AluReady = (count < DEPTH). It depends only on state.
- Each cycle, select at most one source into the output register:
  - count == DEPTH: FIFO head wins; LdReady=0.
  - otherwise, if LdValid: load wins; LdReady=1; head waits.
  - otherwise, if count > 0: FIFO head.
  - otherwise: nothing selected; WriteReg goes to 0 next cycle.
- Push and pop in the same cycle are legal. Count updates as count + push − pop.
- Scoreboard is pending[15:0]:
  - IssueLd sets pending[IssueReg].
  - An accepted load return clears pending[LdReg].
  - If set and clear hit the same register in the same cycle, the set wins.
- Busy1 = pending[QueryReg1] | (any valid FIFO entry with reg == QueryReg1). Busy2 is the same for QueryReg2.
- Busy1 and Busy2 are combinational from the query ports and state.
- Busy excludes the current output register, because the register file bypasses DstData when WriteReg is set and the addresses match.
- Decode stalls on Busy for both RAW and WAW. Therefore no ALU write to a register can be queued while a load to that register is pending, and the block does no reordering.
- Load returns with pending[LdReg]=0 are still written. No error flag is raised.
- Reset (rst=0, asynchronous):
  - FIFO empties, pending=0, WriteReg=0, DstReg=0, DstData=0.
  - Outputs: AluReady=1, LdReady=LdValid, Busy=0.
  - Reset asserted mid-operation discards all queued and pending writes.

## Timing
- Load, accepted in cycle N: WriteReg=1 with LdReg/LdData in cycle N+1. The file is written at the end of cycle N+1.
- ALU, accepted in cycle N with an empty FIFO and no load in cycle N+1: popped in N+1, WriteReg=1 in N+2.
- Sustained ALU traffic alone: one write per cycle after fill.
- When the FIFO is full it pops and rejects the push for a cycle. A waiting load then gets a slot within 2 cycles, so loads never starve.
- Throughput is at most one register-file write per cycle, and there is no idle cycle while a source is waiting.
- Scoreboard set is visible on Busy the cycle after IssueLd. Clear is visible the cycle after the load is accepted, which is the same cycle WriteReg is asserted for that load.

## Test plan
- Reset: hold rst=0 with random inputs → WriteReg=0, DstReg=0, DstData=0, Busy1=Busy2=0, AluReady=1. Release rst, present nothing → outputs stay idle.
- ALU only: AluValid for 3 cycles writing r1=0x0001, r2=0x0002, r3=0x0003, no loads → WriteReg high in cycles 2,3,4 with matching DstReg/DstData. AluReady stays 1 throughout.
- Load priority and fairness:
  - Setup: FIFO holds r4=0xAAAA; load r5=0x5555 presented.
  - Required: r5 written first, then r4.
  - With the FIFO full (DEPTH=2) and LdValid constant: head drains, LdReady=1 within 2 cycles, AluReady=0 on full cycles.
- Scoreboard:
  - IssueLd r7 → Busy1=1 for QueryReg1=7 from the next cycle.
  - Load r7=0x1234 returned → WriteReg/DstReg=7/DstData=0x1234, and Busy1=0 in that same cycle.
  - Same-cycle IssueLd r7 and return r7 → pending[7] stays 1.
- FIFO visibility: push r9 while a load holds priority → Busy2=1 for QueryReg2=9 until r9 leaves the FIFO, then 0.
- Reset mid-operation: FIFO full, pending={r3,r8}, assert rst asynchronously mid-cycle → WriteReg drops immediately, Busy=0. After release, a late load return to r3 is still written.

Source files
------------

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Writeback arbiter in front of a 16x16-bit register file with one write
// port. Single-cycle ALU results are buffered in a small FIFO. Variable-latency
// load returns bypass the FIFO and have priority unless the FIFO is full. The
// winner of each cycle is registered onto DstReg/WriteReg/DstData.
//
// A per-register load scoreboard, combined with a search of the FIFO, tells
// decode which source registers still have a write in flight.
//
// Ports
//   clk                 clock, all state on the rising edge
//   rst                 asynchronous active-low reset
//   AluValid/AluReg/AluData, AluReady   ALU result handshake
//   LdValid/LdReg/LdData,   LdReady     load return handshake
//   IssueLd/IssueReg                    decode issues a load (sets scoreboard)
//   QueryReg1/2 -> Busy1/2              pending-write lookup for decode
//   DstReg/WriteReg/DstData             registered register-file write port
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        AluValid,
    input  logic [3:0]  AluReg,
    input  logic [15:0] AluData,
    output logic        AluReady,
    input  logic        LdValid,
    input  logic [3:0]  LdReg,
    input  logic [15:0] LdData,
    output logic        LdReady,
    input  logic        IssueLd,
    input  logic [3:0]  IssueReg,
    input  logic [3:0]  QueryReg1,
    input  logic [3:0]  QueryReg2,
    output logic        Busy1,
    output logic        Busy2,
    output logic [3:0]  DstReg,
    output logic        WriteReg,
    output logic [15:0] DstData
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};

    // FIFO is a shift queue: entry 0 is the head, entries [0, count) are valid.
    logic [3:0]    fifoReg_r  [DEPTH];
    logic [15:0]   fifoData_r [DEPTH];
    logic [CW-1:0] count_r;
    logic [15:0]   pending_r;

    logic [3:0]    fifoRegNext_s  [DEPTH];
    logic [15:0]   fifoDataNext_s [DEPTH];
    logic [CW-1:0] countNext_s;
    logic [CW-1:0] wrIdx_s;
    logic [15:0]   pendingNext_s;
    logic          full_s;
    logic          ldAccept_s;
    logic          pop_s;
    logic          push_s;
    logic          selValid_s;
    logic [3:0]    selReg_s;
    logic [15:0]   selData_s;
    logic          hit1_s;
    logic          hit2_s;

    // Arbitration: a full FIFO forces a pop, otherwise a load wins over the head.
    always_comb begin
        full_s     = (count_r == DEPTH_C);
        ldAccept_s = ~full_s & LdValid;
        pop_s      = ~ldAccept_s & (count_r != ZERO_C);
        push_s     = AluValid & ~full_s;
        AluReady   = ~full_s;
        LdReady    = ldAccept_s;
        if (ldAccept_s) begin
            selValid_s = 1'b1;
            selReg_s   = LdReg;
            selData_s  = LdData;
        end else if (pop_s) begin
            selValid_s = 1'b1;
            selReg_s   = fifoReg_r[0];
            selData_s  = fifoData_r[0];
        end else begin
            // Nothing to write: address/data hold, only the enable drops.
            selValid_s = 1'b0;
            selReg_s   = DstReg;
            selData_s  = DstData;
        end
    end

    // FIFO next state: shift on pop, then append the push behind the survivors.
    always_comb begin
        countNext_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
        wrIdx_s     = count_r - {{(CW-1){1'b0}}, pop_s};
        fifoRegNext_s  = fifoReg_r;
        fifoDataNext_s = fifoData_r;
        for (int i = 0; i < DEPTH - 1; i++) begin
            fifoRegNext_s[i]  = pop_s ? fifoReg_r[i+1]  : fifoReg_r[i];
            fifoDataNext_s[i] = pop_s ? fifoData_r[i+1] : fifoData_r[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            fifoRegNext_s[i]  = (push_s && (wrIdx_s == CW'(i))) ? AluReg  : fifoRegNext_s[i];
            fifoDataNext_s[i] = (push_s && (wrIdx_s == CW'(i))) ? AluData : fifoDataNext_s[i];
        end
    end

    // Scoreboard next state: accepted return clears, issue sets; set applied last so it wins.
    always_comb begin
        pendingNext_s = pending_r & ~(ldAccept_s ? (16'h0001 << LdReg) : 16'h0000);
        pendingNext_s = pendingNext_s | (IssueLd ? (16'h0001 << IssueReg) : 16'h0000);
    end

    // Busy lookup: scoreboard bit or any valid FIFO entry targeting the queried register.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1_s = hit1_s | ((CW'(i) < count_r) && (fifoReg_r[i] == QueryReg1));
            hit2_s = hit2_s | ((CW'(i) < count_r) && (fifoReg_r[i] == QueryReg2));
        end
        Busy1 = pending_r[QueryReg1] | hit1_s;
        Busy2 = pending_r[QueryReg2] | hit2_s;
    end

    // State and registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r   <= ZERO_C;
            pending_r <= 16'h0000;
            WriteReg  <= 1'b0;
            DstReg    <= 4'h0;
            DstData   <= 16'h0000;
            for (int i = 0; i < DEPTH; i++) begin
                fifoReg_r[i]  <= 4'h0;
                fifoData_r[i] <= 16'h0000;
            end
        end else begin
            count_r   <= countNext_s;
            pending_r <= pendingNext_s;
            WriteReg  <= selValid_s;
            DstReg    <= selReg_s;
            DstData   <= selData_s;
            for (int i = 0; i < DEPTH; i++) begin
                fifoReg_r[i]  <= fifoRegNext_s[i];
                fifoData_r[i] <= fifoDataNext_s[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed scenarios followed by random traffic. A queue-based reference
// model predicts AluReady/LdReady/Busy at mid-cycle and the registered write
// port just after each rising edge.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        AluValid;
    logic [3:0]  AluReg;
    logic [15:0] AluData;
    logic        AluReady;
    logic        LdValid;
    logic [3:0]  LdReg;
    logic [15:0] LdData;
    logic        LdReady;
    logic        IssueLd;
    logic [3:0]  IssueReg;
    logic [3:0]  QueryReg1;
    logic [3:0]  QueryReg2;
    logic        Busy1;
    logic        Busy2;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: pending ALU writes in order, load scoreboard, write port.
    logic [19:0] aluQ [$];
    bit          pend [16];
    logic        expWe;
    logic [3:0]  expReg;
    logic [15:0] expData;
    logic        lastLdReady;
    int          waitCnt;
    int          maxWait;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
        .LdValid(LdValid), .LdReg(LdReg), .LdData(LdData), .LdReady(LdReady),
        .IssueLd(IssueLd), .IssueReg(IssueReg),
        .QueryReg1(QueryReg1), .QueryReg2(QueryReg2), .Busy1(Busy1), .Busy2(Busy2),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit busyOf(input logic [3:0] r);
        if (pend[r]) return 1'b1;
        foreach (aluQ[i]) if (aluQ[i][19:16] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelReset();
        aluQ.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        expWe   = 1'b0;
        expReg  = 4'h0;
        expData = 16'h0000;
    endtask

    task automatic setIdle();
        AluValid = 1'b0; AluReg = 4'h0; AluData = 16'h0000;
        LdValid  = 1'b0; LdReg  = 4'h0; LdData  = 16'h0000;
        IssueLd  = 1'b0; IssueReg = 4'h0;
    endtask

    task automatic randInputs();
        AluValid  = 1'($urandom_range(0, 1));
        AluReg    = 4'($urandom);
        AluData   = 16'($urandom);
        LdValid   = 1'($urandom_range(0, 1));
        LdReg     = 4'($urandom);
        LdData    = 16'($urandom);
        IssueLd   = 1'($urandom_range(0, 1));
        IssueReg  = 4'($urandom);
        QueryReg1 = 4'($urandom);
        QueryReg2 = 4'($urandom);
    endtask

    // One clock: mid-cycle check of combinational outputs, model step, post-edge check.
    task automatic cycle();
        bit          full;
        bit          ldAcc;
        logic [19:0] e;
        @(negedge clk);
        if (!rst) modelReset();
        full = (aluQ.size() == DEPTH);
        check("AluReady", 32'(AluReady), 32'(!full));
        check("LdReady",  32'(LdReady),  32'(!full && LdValid));
        check("Busy1",    32'(Busy1),    32'(busyOf(QueryReg1)));
        check("Busy2",    32'(Busy2),    32'(busyOf(QueryReg2)));
        lastLdReady = LdReady;
        if (rst) begin
            ldAcc = !full && LdValid;
            if (ldAcc) begin
                expWe = 1'b1; expReg = LdReg; expData = LdData;
                pend[LdReg] = 1'b0;
            end else if (aluQ.size() > 0) begin
                e = aluQ.pop_front();
                expWe = 1'b1; expReg = e[19:16]; expData = e[15:0];
            end else begin
                expWe = 1'b0;
            end
            if (AluValid && !full) aluQ.push_back({AluReg, AluData});
            if (IssueLd) pend[IssueReg] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!rst) modelReset();
        check("WriteReg", 32'(WriteReg), 32'(expWe));
        if (expWe || !rst) begin
            check("DstReg",  32'(DstReg),  32'(expReg));
            check("DstData", 32'(DstData), 32'(expData));
        end
    endtask

    initial begin
        rst = 1'b0;
        setIdle();
        QueryReg1 = 4'h0;
        QueryReg2 = 4'h0;
        modelReset();

        // Reset held with random inputs, then idle after release.
        for (int k = 0; k < 4; k++) begin
            randInputs();
            cycle();
        end
        rst = 1'b1;
        setIdle();
        QueryReg1 = 4'h1;
        QueryReg2 = 4'h2;
        cycle();
        cycle();

        // ALU only: r1..r3, written two cycles after acceptance.
        for (int r = 1; r <= 3; r++) begin
            AluValid = 1'b1; AluReg = 4'(r); AluData = 16'(r);
            cycle();
        end
        setIdle();
        for (int k = 0; k < 3; k++) cycle();

        // Load priority over a waiting FIFO head.
        AluValid = 1'b1; AluReg = 4'h4; AluData = 16'hAAAA;
        cycle();
        setIdle();
        LdValid = 1'b1; LdReg = 4'h5; LdData = 16'h5555;
        cycle();
        check("prio_first", 32'(DstReg), 32'h5);
        setIdle();
        cycle();
        check("prio_second", 32'(DstReg), 32'h4);
        check("prio_second_data", 32'(DstData), 32'hAAAA);

        // Full FIFO with a constantly presented load: the load must not starve.
        waitCnt = 0;
        maxWait = 0;
        for (int k = 0; k < 10; k++) begin
            AluValid = 1'b1; AluReg = 4'($urandom_range(10, 15)); AluData = 16'($urandom);
            LdValid  = 1'b1; LdReg  = 4'($urandom_range(10, 15)); LdData  = 16'($urandom);
            cycle();
            waitCnt = lastLdReady ? 0 : waitCnt + 1;
            if (waitCnt > maxWait) maxWait = waitCnt;
        end
        check("ld_no_starve", 32'(maxWait <= 2), 32'h1);
        setIdle();
        for (int k = 0; k < 3; k++) cycle();

        // Scoreboard set, clear on return, and set-wins on collision.
        QueryReg1 = 4'h7;
        IssueLd = 1'b1; IssueReg = 4'h7;
        cycle();
        check("sb_busy_after_issue", 32'(Busy1), 32'h1);
        setIdle();
        LdValid = 1'b1; LdReg = 4'h7; LdData = 16'h1234;
        cycle();
        check("sb_ret_we",   32'(WriteReg), 32'h1);
        check("sb_ret_reg",  32'(DstReg),   32'h7);
        check("sb_ret_data", 32'(DstData),  32'h1234);
        check("sb_cleared",  32'(Busy1),    32'h0);
        setIdle();
        IssueLd = 1'b1; IssueReg = 4'h7;
        cycle();
        LdValid = 1'b1; LdReg = 4'h7; LdData = 16'h0777;
        cycle();
        check("sb_set_wins", 32'(Busy1), 32'h1);
        setIdle();
        LdValid = 1'b1; LdReg = 4'h7; LdData = 16'h0778;
        cycle();
        check("sb_final_clear", 32'(Busy1), 32'h0);
        setIdle();
        cycle();

        // FIFO entry visible on Busy2 while a load holds priority.
        QueryReg2 = 4'h9;
        AluValid = 1'b1; AluReg = 4'h9; AluData = 16'h0909;
        LdValid  = 1'b1; LdReg  = 4'h2; LdData  = 16'h2222;
        cycle();
        AluValid = 1'b0;
        LdReg = 4'h6; LdData = 16'h6666;
        cycle();
        check("fifo_busy_held", 32'(Busy2), 32'h1);
        setIdle();
        cycle();
        check("fifo_drain_reg", 32'(DstReg), 32'h9);
        check("fifo_busy_gone", 32'(Busy2), 32'h0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            randInputs();
            cycle();
        end

        // Reset mid-operation with a full FIFO and loads pending on r3 and r8.
        setIdle();
        for (int k = 0; k < 4; k++) cycle();
        QueryReg1 = 4'h3;
        QueryReg2 = 4'h8;
        AluValid = 1'b1; AluReg = 4'h1; AluData = 16'h1111;
        LdValid  = 1'b1; LdReg  = 4'hC; LdData  = 16'hCCCC;
        IssueLd  = 1'b1; IssueReg = 4'h3;
        cycle();
        AluReg = 4'h2; AluData = 16'h2222;
        IssueReg = 4'h8;
        cycle();
        check("mid_full", 32'(AluReady), 32'h0);
        check("mid_busy_pre", 32'(Busy1 & Busy2), 32'h1);
        setIdle();
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_we",    32'(WriteReg), 32'h0);
        check("mid_rst_busy1", 32'(Busy1),    32'h0);
        check("mid_rst_busy2", 32'(Busy2),    32'h0);
        check("mid_rst_ready", 32'(AluReady), 32'h1);
        modelReset();
        cycle();
        rst = 1'b1;
        LdValid = 1'b1; LdReg = 4'h3; LdData = 16'hBEEF;
        cycle();
        check("late_ld_we",   32'(WriteReg), 32'h1);
        check("late_ld_reg",  32'(DstReg),   32'h3);
        check("late_ld_data", 32'(DstData),  32'hBEEF);
        setIdle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
